cpu_dcache: RTL and testbench

CPU_DCACHE -- requirements
Module: cpu_dcache

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_dcache_ram.sv | 57 +++++
 rtl/cpu_dcache.sv | 191 +++++++++++++++++++
 tb/tb_cpu_dcache.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data cache: FSM state encoding,
// the default uncached region and a byte-lane merge helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MEM_READ  = 3'd2,
        MEM_WRITE = 3'd3,
        DONE      = 3'd4
    } dcache_state_t;

    // addr[31:28] value that selects the uncached (I/O) region
    localparam logic [3:0] IO_BASE_DEFAULT = 4'hE;

    // Replace the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cpu_dcache_ram.sv
// Tag/data/valid storage for the direct-mapped data cache.
// Tag and data are synchronous-read arrays with per-byte data writes;
// valid bits are flops so they can all be cleared by reset.
module cpu_dcache_ram #(
    parameter int LINES = 256,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic              wr_alloc,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_q;

    // Array writes (byte-lane data, tag only on allocate) and synchronous read
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (wr_alloc) tag_mem[wr_index] <= wr_tag;
        end
        rd_tag  <= tag_mem[rd_index];
        rd_data <= data_mem[rd_index];
    end

    // Valid bits: cleared asynchronously, set when a line is allocated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en && wr_alloc) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Registered valid lookup, aligned with the tag/data read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= valid_q[rd_index];
        end
    end

endmodule

// File: rtl/cpu_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with
// one-word lines and an uncached I/O region.
// Handshakes: the CPU holds cpud_request with stable fields until the
// one-cycle cpud_ack pulse; the cache holds mem_request with stable
// fields until the one-cycle mem_ack pulse and drops it the next cycle.
module cpu_dcache
    import cpu_pkg::*;
#(
    parameter int         LINES   = 256,
    parameter logic [3:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpud_request,
    input  logic [31:0]   cpud_addr,
    input  logic          cpud_write,
    input  logic [3:0]    cpud_byte_enable,
    input  logic [31:0]   cpud_wdata,
    output logic [31:0]   cpud_rdata,
    output logic          cpud_ack,
    output logic          mem_request,
    output logic [31:0]   mem_addr,
    output logic          mem_write,
    output logic [3:0]    mem_byte_enable,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output dcache_state_t debug_state
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    dcache_state_t state, state_next;

    logic [29:0]      req_waddr;
    logic             req_write;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic             req_uncached;
    logic [31:0]      fill_data;

    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             hit;

    logic [IDX_W-1:0] ram_rd_index;
    logic             ram_rd_valid;
    logic [TAG_W-1:0] ram_rd_tag;
    logic [31:0]      ram_rd_data;
    logic             ram_wr_en;
    logic             ram_wr_alloc;
    logic [3:0]       ram_wr_be;
    logic [31:0]      ram_wr_data;

    // Byte offset is irrelevant for word accesses
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpud_addr[1:0];

    assign req_index   = req_waddr[IDX_W-1:0];
    assign req_tag     = req_waddr[29:IDX_W];
    assign hit         = ram_rd_valid && (ram_rd_tag == req_tag) && !req_uncached;
    assign debug_state = state;

    cpu_dcache_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ram (
        .clock    (clock),
        .reset    (reset),
        .rd_index (ram_rd_index),
        .rd_valid (ram_rd_valid),
        .rd_tag   (ram_rd_tag),
        .rd_data  (ram_rd_data),
        .wr_en    (ram_wr_en),
        .wr_alloc (ram_wr_alloc),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_be    (ram_wr_be),
        .wr_data  (ram_wr_data)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, CPU response and array write controls
    always_comb begin
        state_next   = state;
        cpud_ack     = 1'b0;
        cpud_rdata   = '0;
        ram_rd_index = req_index;
        ram_wr_en    = 1'b0;
        ram_wr_alloc = 1'b0;
        ram_wr_be    = '0;
        ram_wr_data  = '0;
        case (state)
            IDLE: begin
                // Read the index being latched so the line is ready in LOOKUP
                ram_rd_index = cpud_addr[IDX_W+1:2];
                if (cpud_request) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (req_write) begin
                    state_next = MEM_WRITE;
                    if (hit) begin
                        ram_wr_en   = 1'b1;
                        ram_wr_be   = req_be;
                        ram_wr_data = req_wdata;
                    end
                end else if (hit) begin
                    cpud_ack   = 1'b1;
                    cpud_rdata = ram_rd_data;
                    state_next = IDLE;
                end else begin
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                if (mem_ack) begin
                    state_next = DONE;
                    if (!req_uncached) begin
                        ram_wr_en    = 1'b1;
                        ram_wr_alloc = 1'b1;
                        ram_wr_be    = 4'hF;
                        ram_wr_data  = mem_rdata;
                    end
                end
            end
            MEM_WRITE: begin
                if (mem_ack) state_next = DONE;
            end
            DONE: begin
                cpud_ack   = 1'b1;
                cpud_rdata = req_write ? 32'h0 : fill_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the CPU request on acceptance and the memory read data on ack
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_waddr    <= '0;
            req_write    <= 1'b0;
            req_be       <= '0;
            req_wdata    <= '0;
            req_uncached <= 1'b0;
            fill_data    <= '0;
        end else begin
            if (state == IDLE && cpud_request) begin
                req_waddr    <= cpud_addr[31:2];
                req_write    <= cpud_write;
                req_be       <= cpud_byte_enable;
                req_wdata    <= cpud_wdata;
                req_uncached <= (cpud_addr[31:28] == IO_BASE);
            end
            if (state == MEM_READ && mem_ack) begin
                fill_data <= mem_rdata;
            end
        end
    end

    // Memory-side request: loaded when LOOKUP leaves for memory, dropped after mem_ack
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_request     <= 1'b0;
            mem_addr        <= '0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
        end else if (state == LOOKUP &&
                     (state_next == MEM_READ || state_next == MEM_WRITE)) begin
            mem_request     <= 1'b1;
            mem_addr        <= {req_waddr, 2'b00};
            mem_write       <= req_write;
            mem_byte_enable <= req_write ? req_be : 4'hF;
            mem_wdata       <= req_write ? req_wdata : 32'h0;
        end else if ((state == MEM_READ || state == MEM_WRITE) && mem_ack) begin
            mem_request <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_dcache.sv
// Bench for cpu_dcache: directed scenarios plus randomized traffic,
// checked against a word-level memory model and a line-occupancy model.
module tb_cpu_dcache;
    import cpu_pkg::*;

    localparam int LINES = 256;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpud_request = 1'b0;
    logic [31:0]   cpud_addr = '0;
    logic          cpud_write = 1'b0;
    logic [3:0]    cpud_byte_enable = '0;
    logic [31:0]   cpud_wdata = '0;
    logic [31:0]   cpud_rdata;
    logic          cpud_ack;
    logic          mem_request;
    logic [31:0]   mem_addr;
    logic          mem_write;
    logic [3:0]    mem_byte_enable;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;
    dcache_state_t debug_state;

    always #5 clock = ~clock;

    cpu_dcache #(.LINES(LINES), .IO_BASE(4'hE)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .debug_state      (debug_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Word-addressed backing memory; untouched words have a fixed pattern
    logic [31:0] mem_model [logic [29:0]];

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Which word address each line currently holds (cache contents = memory, write-through)
    bit          line_valid [LINES];
    logic [29:0] line_waddr [LINES];

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) line_valid[i] = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    int          mem_delay = 0;
    bit          mem_hold = 1'b0;
    bit          busy = 1'b0;
    int          wait_left = 0;
    logic [31:0] cap_addr, last_addr;
    logic        cap_write, last_write;
    logic [3:0]  cap_be, last_be;
    logic [31:0] cap_wdata, last_wdata;
    int          n_reads = 0;
    int          n_writes = 0;
    bit          stable_bad = 1'b0;
    bit          state_bad = 1'b0;

    always @(posedge clock) begin
        #1;
        if (!mem_hold) begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (!reset || !mem_request) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy      = 1'b1;
                    wait_left = mem_delay;
                    cap_addr  = mem_addr;
                    cap_write = mem_write;
                    cap_be    = mem_byte_enable;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_write !== cap_write ||
                             mem_byte_enable !== cap_be || mem_wdata !== cap_wdata) begin
                    stable_bad = 1'b1;
                end
                if (wait_left == 0) begin
                    mem_ack    = 1'b1;
                    busy       = 1'b0;
                    last_addr  = cap_addr;
                    last_write = cap_write;
                    last_be    = cap_be;
                    last_wdata = cap_wdata;
                    if (cap_write) begin
                        n_writes++;
                        mem_model[cap_addr[31:2]] = byte_merge(mem_word(cap_addr[31:2]), cap_wdata, cap_be);
                    end else begin
                        n_reads++;
                        mem_rdata = mem_word(cap_addr[31:2]);
                    end
                end else begin
                    wait_left--;
                end
            end
            if (mem_request && !(debug_state == MEM_READ || debug_state == MEM_WRITE))
                state_bad = 1'b1;
        end
    end

    // ---------------- driver task ----------------
    task automatic cpu_access(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] rd);
        logic [29:0] wa;
        int          idx;
        bit          unc, exp_hit, got, rdata_bad;
        int          lat, rd0, wr0;
        logic [31:0] exp_data, data;
        wa        = addr[31:2];
        idx       = int'(wa % LINES);
        unc       = (addr[31:28] == 4'hE);
        exp_hit   = !unc && line_valid[idx] && (line_waddr[idx] == wa);
        exp_data  = mem_word(wa);
        rd0       = n_reads;
        wr0       = n_writes;
        got       = 1'b0;
        rdata_bad = 1'b0;
        lat       = 0;
        data      = '0;

        @(posedge clock); #1;
        cpud_request     = 1'b1;
        cpud_addr        = addr;
        cpud_write       = wr;
        cpud_byte_enable = wr ? be : 4'hF;
        cpud_wdata       = wdata;
        while (!got && lat < 100) begin
            @(negedge clock);
            lat++;
            if (cpud_ack) begin
                got  = 1'b1;
                data = cpud_rdata;
            end else if (cpud_rdata !== 32'h0) begin
                rdata_bad = 1'b1;
            end
        end
        @(posedge clock); #1;
        cpud_request = 1'b0;
        rd = data;

        check_eq("ack_seen", 32'(got), 32'd1);
        if (got) begin
            @(negedge clock);
            check_eq("ack_one_cycle", 32'(cpud_ack), 32'd0);
            check_eq("rdata_zero_idle", 32'(rdata_bad), 32'd0);
            if (!wr) check_eq("load_data", data, exp_data);
            if (!wr && exp_hit) check_eq("hit_latency", 32'(lat), 32'd2);
            check_eq("mem_reads", 32'(n_reads - rd0), (!wr && !exp_hit) ? 32'd1 : 32'd0);
            check_eq("mem_writes", 32'(n_writes - wr0), wr ? 32'd1 : 32'd0);
            if (wr || !exp_hit) begin
                check_eq("mem_addr", last_addr, {wa, 2'b00});
                check_eq("mem_be", 32'(last_be), wr ? 32'(be) : 32'hF);
                if (wr) check_eq("mem_wdata", last_wdata, wdata);
            end
        end
        if (!wr && !exp_hit && !unc) begin
            line_valid[idx] = 1'b1;
            line_waddr[idx] = wa;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        int          acks;
        model_clear();

        // Reset state
        #12;
        check_eq("rst_ack", 32'(cpud_ack), 32'd0);
        check_eq("rst_rdata", cpud_rdata, 32'd0);
        check_eq("rst_mem_req", 32'(mem_request), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_mem_be", 32'(mem_byte_enable), 32'd0);
        check_eq("rst_state", 32'(debug_state), 32'(IDLE));
        @(posedge clock); #1;
        reset = 1'b1;

        // Fill, hit, store-merge
        mem_model[30'h40] = 32'hDEADBEEF;
        cpu_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, rd);
        check_eq("fill_data", rd, 32'hDEADBEEF);
        cpu_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, rd);
        check_eq("hit_data", rd, 32'hDEADBEEF);
        cpu_access(32'h0000_0100, 1'b1, 4'b0011, 32'h0000_1234, rd);
        cpu_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, rd);
        check_eq("merged_data", rd, 32'hDEAD1234);

        // Conflict on the same index evicts the line
        cpu_access(32'h0000_0500, 1'b0, 4'hF, 32'h0, rd);
        cpu_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, rd);

        // Uncached loads never allocate: line 0 stays resident
        cpu_access(32'h0000_0000, 1'b0, 4'hF, 32'h0, rd);
        cpu_access(32'hE000_0000, 1'b0, 4'hF, 32'h0, rd);
        cpu_access(32'hE000_0000, 1'b0, 4'hF, 32'h0, rd);
        cpu_access(32'h0000_0000, 1'b0, 4'hF, 32'h0, rd);

        // Slow memory
        mem_delay = 5;
        cpu_access(32'h0000_0300, 1'b0, 4'hF, 32'h0, rd);
        cpu_access(32'h0000_0300, 1'b1, 4'b1100, 32'hCAFE_0000, rd);
        cpu_access(32'h0000_0300, 1'b0, 4'hF, 32'h0, rd);
        mem_delay = 0;

        // Reset in the middle of a memory read, then a stray mem_ack
        mem_hold = 1'b1;
        @(posedge clock); #1;
        cpud_request     = 1'b1;
        cpud_addr        = 32'h0000_0200;
        cpud_write       = 1'b0;
        cpud_byte_enable = 4'hF;
        for (int i = 0; i < 20 && !mem_request; i++) @(negedge clock);
        check_eq("abort_req_seen", 32'(mem_request), 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_eq("abort_req_drop", 32'(mem_request), 32'd0);
        check_eq("abort_state", 32'(debug_state), 32'(IDLE));
        @(posedge clock); #1;
        reset        = 1'b1;
        cpud_request = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = 32'h1111_1111;
        @(posedge clock); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (cpud_ack || mem_request) acks++;
        end
        check_eq("stray_ack_ignored", 32'(acks), 32'd0);
        busy     = 1'b0;
        mem_hold = 1'b0;
        model_clear();
        cpu_access(32'h0000_0100, 1'b0, 4'hF, 32'h0, rd);

        // Randomized traffic over a small address pool to force hits and conflicts
        for (int n = 0; n < 300; n++) begin
            int unsigned t, ix;
            logic        w;
            t  = $urandom_range(0, 3);
            ix = $urandom_range(0, 7);
            ra = (32'(t) << 10) | (32'(ix) << 2);
            if ($urandom_range(0, 7) == 0) ra = ra | 32'hE000_0000;
            w = ($urandom_range(0, 9) < 3);
            mem_delay = $urandom_range(0, 5);
            cpu_access(ra, w, 4'($urandom_range(1, 15)), $urandom, rd);
        end

        check_eq("mem_fields_stable", 32'(stable_bad), 32'd0);
        check_eq("mem_req_state", 32'(state_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
